gate_tt_checker: RTL and testbench
==================================

// Module: gate_tt_checker
//
// PURPOSE
//  Self-checking truth-table sequencer for the basic-gate library: the response-checking end of the gate stimulus.
//  On start, drives every input combination 0..2**N_IN-1 into a combinational gate under test (DUT).
//  Samples the DUT output after a programmable settle time and compares it against an expected truth table.
//  Reports pass/fail, error count and first failing vector; sits beside any gate (or_gate, and_gate, ...) in sim or FPGA.
//
// PARAMETERS
//  N_IN    2  number of DUT inputs; 1..4
//  SETTLE  2  cycles dut_in is held before sampling; 0..15
//
// PORTS
//  clk          in   1          single clock, rising edge
//  rst_n        in   1          asynchronous, active-low reset
//  start        in   1          1-cycle request; accepted only in IDLE or DONE
//  abort        in   1          synchronous abort of a running sweep
//  truth_table  in   2**N_IN    expected DUT output; bit i = expected out for dut_in==i
//  dut_out      in   1          DUT output being checked
//  dut_in       out  N_IN       stimulus vector to DUT
//  busy         out  1          sweep in progress
//  done         out  1          sweep complete; level, held until next start
//  pass         out  1          valid while done; 1 = zero mismatches
//  err_count    out  N_IN+1     mismatch count; saturates never (max 2**N_IN fits)
//  fail_idx     out  N_IN       index of first mismatch; 0 if none
//
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  - Reset (rst_n=0, any time incl. mid-sweep): state=IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, fail_idx=0.
//  - States: IDLE, RUN, DONE.
//  - IDLE/DONE + start=1 + abort=0: snapshot truth_table into exp_q; dut_in<=0, idx<=0, cnt<=0; err_count<=0;
//    fail_idx<=0; done<=0, pass<=0, busy<=1; -> RUN.
//  - RUN, each edge: if cnt<SETTLE then cnt++ (dut_in held). If cnt==SETTLE: sample dut_out.
//    Mismatch when dut_out != exp_q[idx]: err_count++. If first mismatch (err_count==0), fail_idx<=idx.
//    If idx==2**N_IN-1 -> DONE (busy<=0, done<=1, pass<=final err_count==0); else idx++, dut_in<=idx+1, cnt<=0.
//  - Each vector occupies SETTLE+1 cycles. done rises exactly 2**N_IN*(SETTLE+1) edges after the start edge.
//    Default: 12 cycles.
//  - dut_in changes only on vector boundaries; value in RUN always equals idx.
//  - Mismatch on the last vector is counted, and pass reflects it, on the same edge that done rises.
//  - abort=1 in RUN: -> IDLE, busy<=0, done stays 0. dut_in, err_count and fail_idx keep their partial values.
//  - abort and start together: abort wins; start ignored. start during RUN: ignored.
//  - truth_table changes during RUN have no effect (snapshot only).
//  - dut_out containing X/Z in simulation counts as a mismatch (use !==).
//  - SETTLE=0: sample on the edge after drive; every vector is 1 cycle.
//
// STRUCTURE
//  - Package gate_tt_pkg: state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
//    N_IN_MAX=4, SETTLE_MAX=15.
//  - One sub-module: settle_timer (load, en, SETTLE param -> expired). Reused by future sequential gate checkers.
//  - Top contains the FSM, idx/dut_in register, exp_q snapshot, compare/accumulate logic.
//
// TESTING  (DUT = or_gate, N_IN=2, SETTLE=2 unless noted)
//  1 reset then start, truth_table=4'b1110 -> dut_in 0,1,2,3 each 3 cycles; done at +12; pass=1, err_count=0.
//  2 truth_table=4'b1000 (AND pattern) -> err_count=2, fail_idx=1, pass=0, done at +12.
//  3 truth_table=4'b0001 (inverted) -> err_count=4 (3'b100, no wrap), fail_idx=0.
//  4 abort at cycle 5 -> IDLE, busy=0, done=0; restart -> full sweep completes normally.
//  5 rst_n low mid-RUN (async, off-edge) -> all outputs 0 immediately; start and abort same cycle -> stays IDLE.
//  6 SETTLE=0, N_IN=1, truth_table=2'b10 with a wire DUT -> done at +2, pass=1; toggling truth_table in RUN has no effect.

Source files
------------

// File: rtl/gate_tt_pkg.sv
// Shared definitions for the gate truth-table checkers.
//   - State encoding for the sweep FSM (IDLE / RUN / DONE).
//   - Upper bounds on the number of gate inputs and the settle time.
//     The settle counter width is derived from SETTLE_MAX.
package gate_tt_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int N_IN_MAX   = 4;
    localparam int SETTLE_MAX = 15;

    // Counter width that can hold every legal settle value.
    localparam int SETTLE_CW  = $clog2(SETTLE_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/settle_timer.sv
// Settle-time counter for the sequential gate checkers.
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous, active-low reset
//   load     in   restart the count from zero (has priority over en)
//   en       in   advance the count by one; the count stops at SETTLE
//   expired  out  high while the count equals SETTLE
// With SETTLE=0, expired is high whenever the count is at zero, so a
// stimulus vector is sampled on the very next edge after it is driven.
module settle_timer
    import gate_tt_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam logic [SETTLE_CW-1:0] SETTLE_L = SETTLE_CW'(SETTLE);
    localparam logic [SETTLE_CW-1:0] CNT_ONE  = SETTLE_CW'(1);

    logic [SETTLE_CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SETTLE_L)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == SETTLE_L);

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table sequencer and response checker for a combinational gate.
// A start request snapshots the expected truth table, then drives every
// input vector 0..2**N_IN-1 to the gate, holds each for SETTLE+1 cycles,
// and compares the gate output against the snapshot on the last cycle.
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous, active-low reset
//   start        in   begin a sweep (only from IDLE or DONE)
//   abort        in   stop a running sweep; wins over start
//   truth_table  in   expected output, bit i for dut_in == i
//   dut_out      in   output of the gate under test
//   dut_in       out  stimulus vector to the gate
//   busy         out  sweep in progress
//   done         out  sweep complete, held until the next start
//   pass         out  valid with done; 1 when no mismatches were seen
//   err_count    out  number of mismatches (wide enough for all vectors)
//   fail_idx     out  first mismatching vector, 0 when none
module gate_tt_checker
    import gate_tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   truth_table,
    input  logic                 dut_out,
    output logic [N_IN-1:0]      dut_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      fail_idx
);

    localparam int              N_VEC    = 2 ** N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = '1;
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

    state_e              state_q, state_d;
    logic [N_VEC-1:0]    exp_q, exp_d;
    // The vector index doubles as the stimulus register, so dut_in can
    // never disagree with the vector being checked.
    logic [N_IN-1:0]     idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [N_IN:0]       err_q, err_d;
    logic [N_IN-1:0]     fail_q, fail_d;

    logic                tmr_load;
    logic                tmr_en;
    logic                tmr_expired;
    logic                mismatch;

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d  = state_q;
        exp_d    = exp_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        // Case inequality so an X/Z gate output in simulation is a failure.
        mismatch = (dut_out !== exp_q[idx_q]);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    exp_d    = truth_table;
                    idx_d    = '0;
                    err_d    = '0;
                    fail_d   = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    busy_d   = 1'b1;
                    tmr_load = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Partial results stay visible for debug.
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (tmr_expired) begin
                    if (mismatch) begin
                        err_d = err_q + ERR_ONE;
                        if (err_q == '0) begin
                            fail_d = idx_q;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        // pass uses the updated count so a failure on the
                        // last vector shows on the same edge as done.
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                        state_d = S_DONE;
                    end else begin
                        idx_d    = idx_q + IDX_ONE;
                        tmr_load = 1'b1;
                    end
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            exp_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign dut_in    = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_idx  = fail_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker. Instance A: N_IN=2, SETTLE=2; instance B:
// N_IN=1, SETTLE=0. Each gate under test is a lookup table (fn_*) so both
// the real gate and faulty gates can be modelled. Expected results come
// from the truth-table difference: error count = popcount(fn ^ tt),
// first failure = lowest differing bit, sweep length = 2**N*(SETTLE+1).
module tb_gate_tt_checker;

    localparam int NA = 2;
    localparam int SA = 2;
    localparam int NB = 1;
    localparam int SB = 0;
    localparam int LEN_A = (2 ** NA) * (SA + 1);
    localparam int LEN_B = (2 ** NB) * (SB + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic            start_a, abort_a;
    logic [3:0]      tt_a, fn_a;
    logic            dut_out_a;
    logic [NA-1:0]   dut_in_a;
    logic            busy_a, done_a, pass_a;
    logic [NA:0]     err_a;
    logic [NA-1:0]   fail_a;

    logic            start_b, abort_b;
    logic [1:0]      tt_b, fn_b;
    logic            dut_out_b;
    logic [NB-1:0]   dut_in_b;
    logic            busy_b, done_b, pass_b;
    logic [NB:0]     err_b;
    logic [NB-1:0]   fail_b;

    assign dut_out_a = fn_a[dut_in_a];
    assign dut_out_b = fn_b[dut_in_b];

    gate_tt_checker #(.N_IN(NA), .SETTLE(SA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .truth_table(tt_a), .dut_out(dut_out_a), .dut_in(dut_in_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_idx(fail_a)
    );

    gate_tt_checker #(.N_IN(NB), .SETTLE(SB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .truth_table(tt_b), .dut_out(dut_out_b), .dut_in(dut_in_b),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_idx(fail_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int popc(input logic [15:0] v);
        int c = 0;
        for (int i = 0; i < 16; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic int first_bit(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Full sweep on instance A. Edges are numbered from the start edge (0);
    // outputs are sampled on the falling edge after each one.
    task automatic sweep_a(input logic [3:0] tt, input logic [3:0] fn);
        logic [3:0] diff;
        diff = tt ^ fn;
        @(negedge clk);
        fn_a = fn; tt_a = tt; start_a = 1'b1;
        for (int e = 0; e <= LEN_A; e++) begin
            @(negedge clk);
            if (e == 0) begin
                start_a = 1'b0;
                tt_a = 4'($urandom);   // must be ignored: snapshot only
            end
            if (e < LEN_A) begin
                check("a_busy", 32'(busy_a), 32'd1);
                check("a_done_early", 32'(done_a), 32'd0);
                check("a_dut_in", 32'(dut_in_a), 32'(e / (SA + 1)));
            end else begin
                check("a_done", 32'(done_a), 32'd1);
                check("a_busy_end", 32'(busy_a), 32'd0);
                check("a_err", 32'(err_a), 32'(popc(16'(diff))));
                check("a_fail_idx", 32'(fail_a), 32'(first_bit(16'(diff))));
                check("a_pass", 32'(pass_a), 32'(diff == 4'd0));
            end
        end
        $display("sweep A tt=%b fn=%b err=%0d fail_idx=%0d pass=%0b",
                 tt, fn, err_a, fail_a, pass_a);
    endtask

    task automatic sweep_b(input logic [1:0] tt, input logic [1:0] fn);
        logic [1:0] diff;
        diff = tt ^ fn;
        @(negedge clk);
        fn_b = fn; tt_b = tt; start_b = 1'b1;
        for (int e = 0; e <= LEN_B; e++) begin
            @(negedge clk);
            if (e == 0) begin
                start_b = 1'b0;
                tt_b = ~tt;            // must be ignored: snapshot only
            end
            if (e < LEN_B) begin
                check("b_busy", 32'(busy_b), 32'd1);
                check("b_done_early", 32'(done_b), 32'd0);
                check("b_dut_in", 32'(dut_in_b), 32'(e));
            end else begin
                check("b_done", 32'(done_b), 32'd1);
                check("b_err", 32'(err_b), 32'(popc(16'(diff))));
                check("b_fail_idx", 32'(fail_b), 32'(first_bit(16'(diff))));
                check("b_pass", 32'(pass_b), 32'(diff == 2'd0));
            end
        end
        $display("sweep B tt=%b fn=%b err=%0d fail_idx=%0d pass=%0b",
                 tt, fn, err_b, fail_b, pass_b);
    endtask

    initial begin
        logic [3:0] or_fn;
        or_fn = 4'b1110;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0; tt_a = '0; fn_a = or_fn;
        start_b = 1'b0; abort_b = 1'b0; tt_b = '0; fn_b = 2'b10;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_dut_in", 32'(dut_in_a), 32'd0);
        rst_n = 1'b1;
        $display("reset released");

        // Directed: OR gate against OR, AND and inverted tables.
        sweep_a(4'b1110, or_fn);
        sweep_a(4'b1000, or_fn);
        sweep_a(4'b0001, or_fn);

        // Abort after five edges of a sweep, during the second vector.
        @(negedge clk);
        tt_a = 4'b0001; fn_a = or_fn; start_a = 1'b1;
        for (int e = 0; e <= 5; e++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        check("abort_dut_in", 32'(dut_in_a), 32'd1);
        check("abort_err", 32'(err_a), 32'(or_fn[0] ^ 1'b1));
        repeat (3) @(negedge clk);
        check("abort_idle_busy", 32'(busy_a), 32'd0);
        check("abort_idle_dut_in", 32'(dut_in_a), 32'd1);
        $display("abort A at edge 6 err=%0d dut_in=%0d", err_a, dut_in_a);
        sweep_a(4'b1110, or_fn);

        // Asynchronous reset in the middle of a sweep, away from any edge.
        @(negedge clk);
        tt_a = 4'b0001; start_a = 1'b1;
        for (int e = 0; e <= 7; e++) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_a), 32'd0);
        check("arst_dut_in", 32'(dut_in_a), 32'd0);
        check("arst_err", 32'(err_a), 32'd0);
        check("arst_fail", 32'(fail_a), 32'd0);
        check("arst_done_pass", 32'({done_a, pass_a}), 32'd0);
        $display("async reset mid-sweep applied");
        @(negedge clk);
        rst_n = 1'b1;

        // start and abort together from IDLE: stays idle.
        @(negedge clk);
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        @(negedge clk);
        check("sa_idle_busy", 32'(busy_a), 32'd0);
        check("sa_idle_done", 32'(done_a), 32'd0);
        $display("start+abort in IDLE ignored");

        // start and abort together from DONE: result held.
        sweep_a(4'b1000, or_fn);
        @(negedge clk);
        start_a = 1'b1; abort_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        @(negedge clk);
        check("sa_done_done", 32'(done_a), 32'd1);
        check("sa_done_busy", 32'(busy_a), 32'd0);
        check("sa_done_err", 32'(err_a), 32'd2);
        $display("start+abort in DONE ignored");

        // Randomized gates and tables on instance A.
        for (int t = 0; t < 8; t++) begin
            logic [3:0] rtt, rfn;
            rtt = 4'($urandom);
            rfn = (t % 2 == 0) ? rtt : 4'($urandom);
            sweep_a(rtt, rfn);
        end

        // Instance B: wire DUT, SETTLE=0, then randomized.
        sweep_b(2'b10, 2'b10);
        for (int t = 0; t < 6; t++) begin
            sweep_b(2'($urandom), 2'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
